// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter sizing helper.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold WIDTH-1 (the last CALC step index).
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width + 1) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_trial_subtractor.sv
// Combinational WIDTH+1-bit trial subtraction for one restoring-division step.
// Produces the low WIDTH bits of the difference and a non-negative flag.
module trial_subtractor
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH:0]   subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             non_negative
);

    logic [WIDTH:0] full;

    // The partial remainder is always below twice the divisor, so the true
    // difference fits in WIDTH+1 signed bits and bit WIDTH is its sign.
    assign full         = minuend - subtrahend;
    assign difference   = full[WIDTH-1:0];
    assign non_negative = ~full[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock in CALC,
// with a dedicated single-cycle path for division by zero.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             non_negative;
    logic             accept;
    logic             zero_div;

    assign accept   = (state == IDLE) && start;
    assign zero_div = (divisor == '0);
    assign busy     = (state == CALC);
    assign done     = (state == DONE);

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    assign partial = {remainder, quotient[WIDTH-1]};

    trial_subtractor #(
        .WIDTH(WIDTH)
    ) u_trial_subtractor (
        .minuend     (partial),
        .subtrahend  ({1'b0, divisor_q}),
        .difference  (diff),
        .non_negative(non_negative)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == LAST_STEP) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            divisor_q   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count     <= '0;
            divisor_q <= divisor;
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= dividend;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            quotient  <= {quotient[WIDTH-2:0], non_negative};
            remainder <= non_negative ? diff : partial[WIDTH-1:0];
            count     <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios followed by random
// divisions, compared against plain integer division in the bench.
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: integer division, all-ones quotient on zero divisor.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'd0);
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'd0);
        checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    // One division; with disturb set, start and operands are scrambled in CALC.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit disturb);
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        logic             exp_z;
        int               k;
        int               busy_cycles;
        model(a, b, exp_q, exp_r, exp_z);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start       = 1'b0;
        k           = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (disturb) begin
                start    = 1'($urandom_range(0, 1));
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("done_latency", 32'(k), (b == 0) ? 32'd1 : 32'(WIDTH + 1));
        checkOutput("busy_cycles", 32'(busy_cycles), (b == 0) ? 32'd0 : 32'(WIDTH));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("quotient", 32'(quotient), 32'(exp_q));
        checkOutput("remainder", 32'(remainder), 32'(exp_r));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(exp_z));
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("quotient_hold", 32'(quotient), 32'(exp_q));
        checkOutput("remainder_hold", 32'(remainder), 32'(exp_r));
        checkOutput("dbz_hold", 32'(div_by_zero), 32'(exp_z));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bit               done_seen;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed divisions");
        applyStimulus(8'd100, 8'd7, 1'b0);
        applyStimulus(8'd255, 8'd1, 1'b0);
        applyStimulus(8'd5, 8'd9, 1'b0);
        applyStimulus(8'd77, 8'd0, 1'b0);
        applyStimulus(8'd200, 8'd13, 1'b1);
        applyStimulus(8'd0, 8'd1, 1'b0);
        applyStimulus(8'd255, 8'd255, 1'b0);

        $display("[TB] reset during CALC");
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkIdleOutputs("abort");
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen = 1'b1;
            if (i == 1) rst = 1'b0;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        applyStimulus(8'd50, 8'd6, 1'b0);

        $display("[TB] random divisions");
        repeat (30) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a division, sampled only in IDLE.
REQ-005 The module SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured on the start-accept edge.
REQ-006 The module SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured on the start-accept edge.
REQ-007 The module SHALL have port busy, output, 1 bit: high while state is CALC.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-009 The module SHALL have port quotient, output, WIDTH bits: registered unsigned quotient.
REQ-010 The module SHALL have port remainder, output, WIDTH bits: registered unsigned remainder.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: registered flag, set when the captured divisor is 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 The FSM SHALL use these transitions: IDLE->CALC on start with nonzero divisor; IDLE->DONE on start with divisor 0; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally; otherwise hold.
REQ-014 On the accept edge, the block SHALL capture the operands, clear the iteration counter, and clear div_by_zero (or set it when the divisor is 0).
REQ-015 Each CALC edge SHALL perform one restoring step: form a partial remainder of WIDTH+1 bits as the old remainder shifted left with the next dividend MSB appended, then trial-subtract the divisor; a non-negative result is kept and the quotient bit is 1, otherwise the partial remainder is restored and the quotient bit is 0.
REQ-016 The final remainder SHALL be strictly less than the divisor, and dividend SHALL equal quotient*divisor+remainder exactly.
REQ-017 Latency: for a nonzero divisor, done SHALL be high in the cycle following the WIDTH-th CALC edge, i.e. WIDTH cycles after the accept edge.
REQ-018 Divide by zero: done SHALL be high in the cycle after the accept edge, with quotient all ones, remainder equal to the dividend and div_by_zero 1.
REQ-019 done SHALL be high only in state DONE, for exactly one cycle per accepted start.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-021 start SHALL be ignored in CALC and DONE, with no queuing; a start held high SHALL be accepted again on the first IDLE edge.
REQ-022 Changes on dividend or divisor after the accept edge SHALL NOT affect the operation in progress.

Reset
REQ-023 While rst is high, the block SHALL be in IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and the counter=0, independent of clk.
REQ-024 When rst is asserted mid-operation, the block SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be handled normally.

Structure
REQ-025 A shared package seq_divider_pkg SHALL hold the state encoding (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-026 One combinational sub-module, trial_subtractor, SHALL be used: a WIDTH+1-bit subtract producing the difference and a non-negative flag; the FSM, counter and registers SHALL stay in seq_divider.

Verification
REQ-027 With WIDTH=8, start with 100/7 -> busy for 8 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0.
REQ-028 Start with 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5.
REQ-029 Start with 77/0 -> done in the cycle after the accept edge, with quotient=255, remainder=77, div_by_zero=1 and busy never high.
REQ-030 Start with 200/13, re-pulse start with 9/3 during CALC, and change the inputs -> a single done pulse with quotient=15, remainder=5.
REQ-031 Assert rst on the 4th CALC cycle of 100/7 -> all outputs 0 immediately, no done pulse; a following start with 50/6 -> quotient=8, remainder=2.
